dist_accum: RTL and testbench

Streaming squared-Euclidean distance engine that feeds the 4-way minimum selector. Each frame, it accepts one vector element per handshake beat together with the matching element of four reference points (candidates 1–4). It accumulates the fixed-point squared difference for each candidate over `LEN` beats, then presents four saturated, non-negative Q-format distances `d0..d3` on a valid/ready output port. Index mapping is fixed: `d0`→candidate 1, `d1`→2, `d2`→3, `d3`→4, matching the selector's `min_idx` encoding.

---
 rtl/dist_accum_if.sv | 29 ++
 rtl/dist_accum.sv | 112 +++++++++++
 tb/tb_dist_accum.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_accum_if.sv
// Handshake bundle for dist_accum: input beats (x, c0..c3) and output distances (d0..d3).
// The master drives beats and accepts results; the slave is the engine itself.
interface dist_accum_if #(
  parameter int N = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] x;
  logic signed [N-1:0] c0;
  logic signed [N-1:0] c1;
  logic signed [N-1:0] c2;
  logic signed [N-1:0] c3;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] d0;
  logic signed [N-1:0] d1;
  logic signed [N-1:0] d2;
  logic signed [N-1:0] d3;

  modport master (
    output in_valid, x, c0, c1, c2, c3, out_ready,
    input  in_ready, out_valid, d0, d1, d2, d3
  );

  modport slave (
    input  in_valid, x, c0, c1, c2, c3, out_ready,
    output in_ready, out_valid, d0, d1, d2, d3
  );
endinterface

// File: rtl/dist_accum.sv
// Streaming squared-Euclidean distance engine: accumulates (x - c_k)^2 >> Q over LEN beats
// for four candidates and presents saturated distances on a valid/ready port.
module dist_accum #(
  parameter int N   = 16,
  parameter int Q   = 8,
  parameter int LEN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  dist_accum_if.slave  bus
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int AW = 2*N + 2 + $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic [AW-1:0] MAXV = AW'({1'b0, {(N-1){1'b1}}});

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              stateQ, stateD;
  logic [CW-1:0]       cntQ;
  logic [AW-1:0]       accQ [4];
  logic [N-1:0]        dQ   [4];

  logic signed [N-1:0]   cv   [4];
  logic signed [N:0]     diff [4];
  logic signed [2*N+1:0] sq   [4];
  logic [2*N+1:0]        sqU  [4];
  logic [AW-1:0]         term [4];
  logic [AW-1:0]         sum  [4];
  logic [N-1:0]          satV [4];
  logic                  accept;
  logic                  lastBeat;

  assign cv[0] = bus.c0;
  assign cv[1] = bus.c1;
  assign cv[2] = bus.c2;
  assign cv[3] = bus.c3;

  assign accept   = bus.in_valid && (stateQ == ACCUM);
  assign lastBeat = accept && (cntQ == LAST);

  // The difference needs N+1 bits; its square is non-negative, so it is reinterpreted as unsigned.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      diff[k] = {bus.x[N-1], bus.x} - {cv[k][N-1], cv[k]};
      sq[k]   = diff[k] * diff[k];
      sqU[k]  = $unsigned(sq[k]);
      term[k] = AW'(sqU[k] >> Q);
      sum[k]  = accQ[k] + term[k];
      satV[k] = (sum[k] > MAXV) ? MAXV[N-1:0] : sum[k][N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= ACCUM;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    if (clr_i) begin
      stateD = ACCUM;
    end else begin
      case (stateQ)
        ACCUM:   if (lastBeat) stateD = HOLD;
        HOLD:    if (bus.out_ready) stateD = ACCUM;
        default: stateD = ACCUM;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (stateQ)
      ACCUM:   bus.in_ready  = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b1;
    endcase
  end

  // Distances are only rewritten on a frame's final beat; clr leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ <= '0;
      for (int k = 0; k < 4; k++) begin
        accQ[k] <= '0;
        dQ[k]   <= '0;
      end
    end else if (clr_i) begin
      cntQ <= '0;
      for (int k = 0; k < 4; k++) accQ[k] <= '0;
    end else if (lastBeat) begin
      cntQ <= '0;
      for (int k = 0; k < 4; k++) begin
        accQ[k] <= '0;
        dQ[k]   <= satV[k];
      end
    end else if (accept) begin
      cntQ <= cntQ + CW'(1);
      for (int k = 0; k < 4; k++) accQ[k] <= sum[k];
    end
  end

  assign bus.d0 = dQ[0];
  assign bus.d1 = dQ[1];
  assign bus.d2 = dQ[2];
  assign bus.d3 = dQ[3];

endmodule

// File: tb/tb_dist_accum.sv
// Directed bench for dist_accum: a LEN=4 engine driven through frames with a result scoreboard,
// plus a LEN=1 engine for saturation and single-beat frames.
module tb_dist_accum;

  logic clk;
  logic rst_n;
  logic clr;

  dist_accum_if #(.N(16)) busA ();
  dist_accum_if #(.N(16)) busB ();

  dist_accum #(.N(16), .Q(8), .LEN(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .bus   (busA)
  );

  dist_accum #(.N(16), .Q(8), .LEN(1)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .bus   (busB)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] q[$];
  longint mAcc [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] dA();
    return {busA.d0, busA.d1, busA.d2, busA.d3};
  endfunction

  function automatic logic [63:0] dB();
    return {busB.d0, busB.d1, busB.d2, busB.d3};
  endfunction

  function automatic longint termOf(logic [15:0] a, logic [15:0] b);
    longint da = longint'($signed(a));
    longint db = longint'($signed(b));
    return ((da - db) * (da - db)) >> 8;
  endfunction

  function automatic logic [15:0] satOf(longint v);
    return (v > 32767) ? 16'h7FFF : v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < 4; k++) mAcc[k] = 0;
  endtask

  task automatic modelPush();
    q.push_back({satOf(mAcc[0]), satOf(mAcc[1]), satOf(mAcc[2]), satOf(mAcc[3])});
    modelClear();
  endtask

  // One clock; a result handshaking on this edge is checked against the scoreboard first.
  task automatic step();
    logic [63:0] e;
    if (busA.out_valid && busA.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL result observed=%h expected=none", dA());
      end else begin
        e = q.pop_front();
        chk("result", dA(), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] x, c0, c1, c2, c3);
    int n = 0;
    busA.x = x; busA.c0 = c0; busA.c1 = c1; busA.c2 = c2; busA.c3 = c3;
    busA.in_valid = 1'b1;
    while (!busA.in_ready && n < 64) begin
      step();
      n++;
    end
    if (!busA.in_ready) begin
      total++;
      bad++;
      $error("[TB] FAIL send_timeout observed=in_ready_low expected=in_ready_high");
    end else begin
      mAcc[0] += termOf(x, c0);
      mAcc[1] += termOf(x, c1);
      mAcc[2] += termOf(x, c2);
      mAcc[3] += termOf(x, c3);
      step();
    end
    busA.in_valid = 1'b0;
  endtask

  task automatic sendRandom();
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic checkOutput(input string tag, input logic ov, input logic ir);
    chk({tag, "_out_valid"}, 64'(busA.out_valid), 64'(ov));
    chk({tag, "_in_ready"},  64'(busA.in_ready),  64'(ir));
  endtask

  initial begin
    logic [15:0] bx, bc0, bc1, bc2, bc3;
    clr = 1'b0;
    rst_n = 1'b1;
    busA.in_valid = 1'b0; busA.out_ready = 1'b1;
    busA.x = '0; busA.c0 = '0; busA.c1 = '0; busA.c2 = '0; busA.c3 = '0;
    busB.in_valid = 1'b0; busB.out_ready = 1'b0;
    busB.x = '0; busB.c0 = '0; busB.c1 = '0; busB.c2 = '0; busB.c3 = '0;
    modelClear();

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset", 1'b0, 1'b1);
    chk("reset_d", dA(), 64'h0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic frame");
    for (int i = 0; i < 4; i++) applyStimulus(16'h0200, 16'h0100, 16'h0200, 16'h0000, 16'hFF00);
    modelClear();
    q.push_back(64'h0400_0000_1000_2400);
    checkOutput("basic_after_beat4", 1'b1, 1'b0);
    step();
    checkOutput("basic_pulse_end", 1'b0, 1'b1);

    $display("[TB] saturation on LEN=1 engine");
    busB.x = 16'h7FFF; busB.c0 = 16'h8000; busB.c1 = 16'h7FFF; busB.c2 = 16'h7FFF; busB.c3 = 16'h0000;
    busB.in_valid = 1'b1;
    step();
    busB.in_valid = 1'b0;
    chk("sat_out_valid", 64'(busB.out_valid), 64'd1);
    chk("sat_d", dB(), 64'h7FFF_0000_0000_7FFF);
    busB.out_ready = 1'b1;
    step();
    busB.out_ready = 1'b0;
    chk("sat_released", 64'(busB.out_valid), 64'd0);
    busB.x = 16'h0100; busB.c0 = 16'h0000; busB.c1 = 16'h0100; busB.c2 = 16'h0300; busB.c3 = 16'hFF00;
    busB.in_valid = 1'b1;
    step();
    busB.in_valid = 1'b0;
    chk("len1_d", dB(), 64'h0100_0000_0400_0400);
    busB.out_ready = 1'b1;
    step();
    busB.out_ready = 1'b0;

    $display("[TB] backpressure");
    busA.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendRandom();
    modelPush();
    bx = 16'h0300; bc0 = 16'h0000; bc1 = 16'hFD00; bc2 = 16'h0280; bc3 = 16'h0300;
    busA.x = bx; busA.c0 = bc0; busA.c1 = bc1; busA.c2 = bc2; busA.c3 = bc3;
    busA.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold", 1'b1, 1'b0);
      chk("bp_d_stable", dA(), q[0]);
      step();
    end
    busA.out_ready = 1'b1;
    step();
    checkOutput("bp_released", 1'b0, 1'b1);
    applyStimulus(bx, bc0, bc1, bc2, bc3);
    for (int i = 0; i < 3; i++) applyStimulus(bx, bc0, bc1, bc2, bc3);
    modelPush();
    step();

    $display("[TB] bubbles");
    for (int i = 0; i < 4; i++) begin
      int gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      applyStimulus(16'h0080 + 16'(i), 16'hFF80, 16'h0100, 16'h8000, 16'h7000);
    end
    modelPush();
    step();
    for (int i = 0; i < 4; i++) applyStimulus(16'h0080 + 16'(i), 16'hFF80, 16'h0100, 16'h8000, 16'h7000);
    modelPush();
    step();

    $display("[TB] abort");
    sendRandom();
    sendRandom();
    busA.x = 16'h7FFF; busA.c0 = 16'h8000; busA.in_valid = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    busA.in_valid = 1'b0;
    modelClear();
    checkOutput("abort_cleared", 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) sendRandom();
    modelPush();
    step();
    busA.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendRandom();
    modelPush();
    checkOutput("hold_before_clr", 1'b1, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    void'(q.pop_back());
    checkOutput("clr_in_hold", 1'b0, 1'b1);
    busA.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 16'h0010, 16'hFFF0, 16'h0000, 16'h0400);
    modelPush();
    step();

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) sendRandom();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset", 1'b0, 1'b1);
    chk("midreset_d", dA(), 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    modelClear();
    for (int i = 0; i < 4; i++) sendRandom();
    modelPush();
    step();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
